mapper_pattern_count: RTL and testbench
=======================================

# mapper_pattern_count

Streaming map stage of the mapreduce user logic. Each instance scans one 32-bit byte stream for a fixed-length byte pattern and keeps a running 32-bit occurrence count, overlapping matches included. Several instances run in parallel, and their `o_data_count` outputs are concatenated into the reducer's per-mapper count bus, which the reducer samples continuously. The block tracks matches across word boundaries and signals end-of-record so software knows when the count is final.

## Interface
- `PATTERN_LEN`, default 4: pattern length in bytes; legal range 1..8.
- `i_clk` input 1: clock.
- `i_rst` input 1: reset, synchronous, active-high; clock `i_clk`.
- `i_clear` input 1: synchronous soft clear. Returns the block to IDLE and zeroes the count and history.
- `i_pattern` input PATTERN_LEN*8: search pattern. `[7:0]` is the first pattern byte. Must be held stable while not IDLE.
- `i_valid` input 1: input word valid.
- `o_ready` output 1: block accepts a word.
- `i_data` input 32: stream word. `[7:0]` is the earliest byte, `[31:24]` the latest.
- `i_keep` input 4: byte enables, honoured only when `i_last`=1. Must be contiguous from bit 0 (`0001`, `0011`, `0111`, `1111`). Treated as `1111` when `i_last`=0.
- `i_last` input 1: final word of the record.
- `o_data_count` output 32: running match count, saturating.
- `o_done` output 1: level. The record is complete and `o_data_count` is final.

## Operation
- **States:** IDLE, RUN, DONE.
- **Handshake:**
  - A word is accepted on a rising edge where `i_valid` && `o_ready`.
  - `o_ready` = (state != DONE) && !`i_clear`.
  - `i_valid` may drop at any time. No data is accepted without `o_ready`.
- **Transitions:**
  - IDLE -> RUN on an accepted word with `i_last`=0.
  - IDLE/RUN -> DONE on an accepted word with `i_last`=1. A single-word record goes IDLE -> DONE directly.
  - DONE -> IDLE only on `i_clear`.
  - Any state -> IDLE on `i_clear` or `i_rst`.
- **History:**
  - The block keeps the last PATTERN_LEN-1 accepted bytes plus a fill counter `hist_fill`, which saturates at PATTERN_LEN-1.
  - Bytes from before the last reset/clear never participate in a match.
- **Match rule:**
  - For each valid byte position p (0..3) of the accepted word, a match ends at p when the PATTERN_LEN bytes ending at p equal `i_pattern` in stream order.
  - The window spans history bytes plus word bytes 0..p.
  - The window is eligible only when `hist_fill` + p + 1 >= PATTERN_LEN.
  - Up to 4 matches per word; all four positions are evaluated in parallel.
- **Count update:**
  - `o_data_count` <= `o_data_count` + matches(word), 3-bit addend.
  - On overflow it holds at 0xFFFF_FFFF.
- **History update:**
  - Shift in the valid bytes (per `i_keep` on the last word).
  - `hist_fill` += number of valid bytes, saturating.
- **Simultaneous events:**
  - `i_rst` beats `i_clear`.
  - `i_clear` beats an offered word. The word is not accepted because `o_ready`=0 that cycle.
- **Reset/clear mid-record:** the partial count and history are discarded. The next accepted word starts a new record.

## Timing
- **Reset values:** `o_data_count`=0, `o_done`=0, `o_ready`=1 (after the reset edge, with `i_clear` low); state IDLE; `hist_fill`=0.
- **Latency:** a word accepted at edge N is reflected in `o_data_count` from the cycle after edge N (one register stage). Full throughput of one word per cycle.
- **Last word:** the count including the last word and `o_done`=1 both become visible at the same edge N. `o_ready` is 0 from that edge.
- **In DONE:** `o_data_count` and `o_done` hold until clear/reset. `o_done` drops and the count reads 0 the cycle after the clear edge.
- **Count visibility:** `o_data_count` is glitch-free registered, and the reducer may sample it in any cycle. Its value is monotonic non-decreasing between clears.

## Test plan
- **Single word:** PATTERN_LEN=4, `i_pattern`=0x64636261 ("abcd"); one word 0x64636261 with `i_last`=1, `i_keep`=F. Expect `o_data_count`=1 and `o_done`=1 one cycle later, and `o_ready`=0.
- **Word-boundary match:** words "xxab" (0x62617878) then "cdxx" (0x78786463, `i_last`). Expect the count to be 0 after word 1 and 1 after word 2.
- **Overlap:** PATTERN_LEN=2, pattern "aa"; words 0x61616161, 0x61616161 (last). Expect counts 3, then 7.
- **Keep mask:** PATTERN_LEN=2, pattern "ab"; single last word 0x62610000 (bytes 2-3 are "ab") with `i_keep`=0011. Expect count 0 and `o_done`=1. Repeat with `i_keep`=1111: expect 1.
- **Backpressure/clear:** after DONE, hold `i_valid`=1 for 5 cycles. Expect no count change and `o_ready`=0. Pulse `i_clear` concurrently with `i_valid`: expect next-cycle count 0, `o_done`=0, state IDLE, and the offered word not accepted.
- **Reset mid-record and saturation:**
  - Assert `i_rst` after 3 of 6 words. Expect count 0, and no match formed from pre-reset history bytes.
  - Force count 0xFFFF_FFFE (via a long all-"a" run with PATTERN_LEN=1, or a bench-forced preload), then a 4-match word. Expect 0xFFFF_FFFF.

Source files
------------

// File: rtl/mapper_pattern_count.sv
// Streaming pattern counter: counts overlapping occurrences of a fixed byte pattern
// across a 32-bit word stream and flags end-of-record with a held final count.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no bytes accepted since reset/clear, history empty
// S_RUN  | inside a record, words being accepted and counted
// S_DONE | last word accepted, count final, input back-pressured
module mapper_pattern_count #(
    parameter int PATTERN_LEN = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic [PATTERN_LEN*8-1:0] i_pattern,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_data,
    input  logic [3:0]               i_keep,
    input  logic                     i_last,
    output logic [31:0]              o_data_count,
    output logic                     o_done
);

    // One history slot is kept even for single-byte patterns so the arrays stay non-empty;
    // the eligibility check never lets it participate in that case.
    localparam int HIST_N   = (PATTERN_LEN > 1) ? PATTERN_LEN - 1 : 1;
    localparam int FILL_MAX = PATTERN_LEN - 1;
    localparam int EXT_N    = HIST_N + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hist [HIST_N];
    logic [3:0]  r_hist_fill;
    logic [31:0] r_count;

    logic        w_accept;
    logic [2:0]  w_nvalid;
    logic [7:0]  w_ext [EXT_N];
    logic [7:0]  w_hist_nxt [HIST_N];
    logic [3:0]  w_hit;
    logic [2:0]  w_nmatch;
    logic [32:0] w_count_sum;
    logic [31:0] w_count_nxt;
    logic [4:0]  w_fill_sum;
    logic [3:0]  w_fill_nxt;

    assign o_ready      = (r_state != S_DONE) && !i_clear;
    assign w_accept     = i_valid && o_ready;
    assign o_done       = (r_state == S_DONE);
    assign o_data_count = r_count;

    always_comb begin
        w_nvalid = 3'd4;
        if (i_last) begin
            case (i_keep)
                4'b0001: w_nvalid = 3'd1;
                4'b0011: w_nvalid = 3'd2;
                4'b0111: w_nvalid = 3'd3;
                default: w_nvalid = 3'd4;
            endcase
        end
    end

    // Oldest history byte at index 0, followed by word bytes in stream order.
    always_comb begin
        for (int i = 0; i < HIST_N; i++) w_ext[i] = r_hist[i];
        for (int j = 0; j < 4; j++) w_ext[HIST_N + j] = i_data[j*8 +: 8];
    end

    always_comb begin
        w_hit = '0;
        for (int p = 0; p < 4; p++) begin
            if ((int'(r_hist_fill) + p + 1 >= PATTERN_LEN) && (p < int'(w_nvalid))) begin
                w_hit[p] = 1'b1;
                for (int k = 0; k < PATTERN_LEN; k++) begin
                    if (w_ext[HIST_N + p - PATTERN_LEN + 1 + k] != i_pattern[k*8 +: 8])
                        w_hit[p] = 1'b0;
                end
            end
        end
        w_nmatch = {2'b0, w_hit[0]} + {2'b0, w_hit[1]} + {2'b0, w_hit[2]} + {2'b0, w_hit[3]};
    end

    always_comb begin
        w_count_sum = {1'b0, r_count} + {30'b0, w_nmatch};
        w_count_nxt = w_count_sum[32] ? 32'hFFFF_FFFF : w_count_sum[31:0];
        w_fill_sum  = {1'b0, r_hist_fill} + {2'b0, w_nvalid};
        w_fill_nxt  = (w_fill_sum >= 5'(FILL_MAX)) ? 4'(FILL_MAX) : w_fill_sum[3:0];
    end

    // Keep the newest HIST_N bytes after shifting in only the valid ones.
    always_comb begin
        for (int i = 0; i < HIST_N; i++) begin
            case (w_nvalid)
                3'd1:    w_hist_nxt[i] = w_ext[i + 1];
                3'd2:    w_hist_nxt[i] = w_ext[i + 2];
                3'd3:    w_hist_nxt[i] = w_ext[i + 3];
                default: w_hist_nxt[i] = w_ext[i + 4];
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear)
            w_state_nxt = S_IDLE;
        else if (w_accept)
            w_state_nxt = i_last ? S_DONE : S_RUN;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_hist_fill <= '0;
            for (int i = 0; i < HIST_N; i++) r_hist[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_clear) begin
                r_count     <= '0;
                r_hist_fill <= '0;
                for (int i = 0; i < HIST_N; i++) r_hist[i] <= '0;
            end else if (w_accept) begin
                r_count     <= w_count_nxt;
                r_hist_fill <= w_fill_nxt;
                for (int i = 0; i < HIST_N; i++) r_hist[i] <= w_hist_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_mapper_pattern_count.sv
// Bench for mapper_pattern_count: three instances (pattern lengths 4, 2, 1) share one stream
// and are compared against a byte-queue reference model; directed steps then random traffic.
module tb_mapper_pattern_count;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic [3:0]  keep = 4'hF;
    logic        last = 1'b0;
    logic [31:0] pat4 = 32'h64636261;
    logic [15:0] pat2 = 16'h6161;
    logic [7:0]  pat1 = 8'h61;

    logic        rdy_o  [3];
    logic [31:0] cnt_o  [3];
    logic        done_o [3];

    int          nchk  = 0;
    int          nfail = 0;

    int          plen [3] = '{4, 2, 1};
    logic [7:0]  pb   [3][8];
    logic [7:0]  mq   [3][$];
    logic [31:0] m_cnt  [3];
    logic        m_done [3];

    always #5 clk = ~clk;

    mapper_pattern_count #(.PATTERN_LEN(4)) u_len4 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_pattern(pat4), .i_valid(valid),
        .o_ready(rdy_o[0]), .i_data(data), .i_keep(keep), .i_last(last),
        .o_data_count(cnt_o[0]), .o_done(done_o[0]));

    mapper_pattern_count #(.PATTERN_LEN(2)) u_len2 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_pattern(pat2), .i_valid(valid),
        .o_ready(rdy_o[1]), .i_data(data), .i_keep(keep), .i_last(last),
        .o_data_count(cnt_o[1]), .o_done(done_o[1]));

    mapper_pattern_count #(.PATTERN_LEN(1)) u_len1 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_pattern(pat1), .i_valid(valid),
        .o_ready(rdy_o[2]), .i_data(data), .i_keep(keep), .i_last(last),
        .o_data_count(cnt_o[2]), .o_done(done_o[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int keep_n(input logic [3:0] k);
        case (k)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b0111: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic load_patterns();
        for (int t = 0; t < 8; t++) begin
            pb[0][t] = (t < 4) ? pat4[t*8 +: 8] : 8'h00;
            pb[1][t] = (t < 2) ? pat2[t*8 +: 8] : 8'h00;
            pb[2][t] = (t < 1) ? pat1 : 8'h00;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_cnt[i]  = '0;
            m_done[i] = 1'b0;
        end
    endtask

    // Stream-level reference: append accepted bytes, test the newest window after each byte.
    task automatic model_edge(input logic v, input logic [31:0] d, input logic [3:0] k,
                              input logic l, input logic c);
        int  n;
        int  sz;
        logic hit;
        if (c) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (v && !m_done[i]) begin
                n = l ? keep_n(k) : 4;
                for (int b = 0; b < n; b++) begin
                    mq[i].push_back(d[b*8 +: 8]);
                    if (mq[i].size() > 8) void'(mq[i].pop_front());
                    sz = mq[i].size();
                    if (sz >= plen[i]) begin
                        hit = 1'b1;
                        for (int t = 0; t < plen[i]; t++)
                            if (mq[i][sz - plen[i] + t] != pb[i][t]) hit = 1'b0;
                        if (hit && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                if (l) m_done[i] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count[L%0d]", plen[i]), cnt_o[i], m_cnt[i]);
            chk($sformatf("done[L%0d]", plen[i]), {31'b0, done_o[i]}, {31'b0, m_done[i]});
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] k,
                         input logic l, input logic c);
        valid = v; data = d; keep = k; last = l; clr = c;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("ready[L%0d]", plen[i]), {31'b0, rdy_o[i]},
                {31'b0, (!m_done[i] && !c)});
        @(posedge clk);
        model_edge(v, d, k, l, c);
        #1;
        check_outputs();
        valid = 1'b0; clr = 1'b0; last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; clr = 1'b0; last = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        rst = 1'b0;
        #1;
        check_outputs();
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_ready[L%0d]", plen[i]), {31'b0, rdy_o[i]}, 32'd1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[b*8 +: 8] = 8'h61 + 8'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        logic [3:0] keeps [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        logic       rv, rl, rc;
        logic [3:0] rk;

        load_patterns();
        model_clear();
        do_reset();
        chk("reset_count", cnt_o[0], 32'd0);

        // single-word record "abcd"
        cycle(1, 32'h64636261, 4'hF, 1, 0);
        chk("single_count", cnt_o[0], 32'd1);
        chk("single_done", {31'b0, done_o[0]}, 32'd1);
        cycle(0, 32'h0, 4'hF, 0, 0);
        chk("single_ready_low", {31'b0, rdy_o[0]}, 32'd0);

        // match spanning a word boundary
        cycle(0, 32'h0, 4'hF, 0, 1);
        cycle(1, 32'h62617878, 4'hF, 0, 0);
        chk("boundary_w1", cnt_o[0], 32'd0);
        cycle(1, 32'h78786463, 4'hF, 1, 0);
        chk("boundary_w2", cnt_o[0], 32'd1);

        // overlapping "aa"
        cycle(0, 32'h0, 4'hF, 0, 1);
        cycle(1, 32'h61616161, 4'hF, 0, 0);
        chk("overlap_w1", cnt_o[1], 32'd3);
        cycle(1, 32'h61616161, 4'hF, 1, 0);
        chk("overlap_w2", cnt_o[1], 32'd7);

        // keep mask hides "ab" in bytes 2-3
        cycle(0, 32'h0, 4'hF, 0, 1);
        pat2 = 16'h6261;
        load_patterns();
        cycle(1, 32'h62610000, 4'b0011, 1, 0);
        chk("keep0011_count", cnt_o[1], 32'd0);
        chk("keep0011_done", {31'b0, done_o[1]}, 32'd1);
        cycle(0, 32'h0, 4'hF, 0, 1);
        cycle(1, 32'h62610000, 4'b1111, 1, 0);
        chk("keep1111_count", cnt_o[1], 32'd1);

        // backpressure in DONE, then clear racing an offered word
        for (int n = 0; n < 5; n++) cycle(1, 32'h62616261, 4'hF, 0, 0);
        chk("bp_hold_count", cnt_o[1], 32'd1);
        cycle(1, 32'h62616261, 4'hF, 1, 1);
        chk("clear_count", cnt_o[1], 32'd0);
        chk("clear_done", {31'b0, done_o[1]}, 32'd0);
        cycle(0, 32'h0, 4'hF, 0, 0);
        cycle(1, 32'h00006261, 4'hF, 1, 0);
        chk("after_clear_count", cnt_o[1], 32'd1);

        // reset mid-record: pre-reset "abc" must not pair with post-reset "d"
        cycle(0, 32'h0, 4'hF, 0, 1);
        cycle(1, 32'h78787878, 4'hF, 0, 0);
        cycle(1, 32'h78787878, 4'hF, 0, 0);
        cycle(1, 32'h63626178, 4'hF, 0, 0);
        do_reset();
        cycle(1, 32'h78787864, 4'hF, 0, 0);
        cycle(1, 32'h78787878, 4'hF, 0, 0);
        cycle(1, 32'h78787878, 4'hF, 1, 0);
        chk("rst_mid_count", cnt_o[0], 32'd0);

        // saturation on the single-byte instance
        cycle(0, 32'h0, 4'hF, 0, 1);
        force u_len1.r_count = 32'hFFFF_FFFE;
        #1;
        release u_len1.r_count;
        m_cnt[2] = 32'hFFFF_FFFE;
        cycle(1, 32'h61616161, 4'hF, 0, 0);
        chk("sat_first", cnt_o[2], 32'hFFFF_FFFF);
        cycle(1, 32'h61616161, 4'hF, 1, 0);
        chk("sat_hold", cnt_o[2], 32'hFFFF_FFFF);

        // random traffic over a small alphabet so matches are frequent
        cycle(0, 32'h0, 4'hF, 0, 1);
        for (int n = 0; n < 800; n++) begin
            rv = ($urandom_range(0, 9) < 7);
            rl = ($urandom_range(0, 7) == 0);
            rk = keeps[$urandom_range(0, 3)];
            rc = m_done[0] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            cycle(rv, rand_word(), rk, rl, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
